ahb_bus_arbiter: RTL

Registered AHB-Lite bus arbiter for the multi-manager interconnect, directly downstream of the fixed-priority selector. It collects per-manager bus requests, passes them through a fixed-priority selector (lowest index wins), and turns the one-hot result into a registered grant. The grant moves only at legal AHB arbitration points: fixed-length bursts and locked sequences complete uninterrupted. It also drives the address-phase and data-phase owner indices that steer the manager-side muxes.

---
 rtl/ahb_pkg.sv | 45 ++++
 rtl/ahb_bus_arbiter_if.sv | 33 +++
 rtl/ahb_bus_arbiter_fixedpriority.sv | 16 +
 rtl/ahb_bus_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : AHB-Lite encodings, arbiter state enum and burst-length helper.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] c_HBURST_SINGLE = 3'b000;
    localparam logic [2:0] c_HBURST_INCR   = 3'b001;
    localparam logic [2:0] c_HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] c_HBURST_INCR4  = 3'b011;
    localparam logic [2:0] c_HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] c_HBURST_INCR8  = 3'b101;
    localparam logic [2:0] c_HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] c_HBURST_INCR16 = 3'b111;

    localparam int c_BEATW = 5;

    typedef enum logic [1:0] {
        ARB_ST_ARB    = 2'd0,
        ARB_ST_BURST  = 2'd1,
        ARB_ST_LOCKED = 2'd2
    } arb_state_e;

    // Beats still owed after the NONSEQ of a fixed-length burst; 0 for undefined length.
    function automatic logic [c_BEATW-1:0] burst_beats(input logic [2:0] hburst);
        logic [c_BEATW-1:0] v_beats;
        v_beats = '0;
        case (hburst)
            c_HBURST_WRAP4,  c_HBURST_INCR4:  v_beats = 5'd3;
            c_HBURST_WRAP8,  c_HBURST_INCR8:  v_beats = 5'd7;
            c_HBURST_WRAP16, c_HBURST_INCR16: v_beats = 5'd15;
            default:                          v_beats = 5'd0;
        endcase
        return v_beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter_if
// Brief    : Request/grant bundle between the managers and the bus arbiter.
// Revision : 1.0
// ============================================================================
interface ahb_bus_arbiter_if #(
    parameter int NMGR = 4,
    parameter int IDXW = $clog2(NMGR)
);
    logic [NMGR-1:0] HBUSREQ;
    logic [NMGR-1:0] HLOCK;
    logic [1:0]      HTRANS;
    logic [2:0]      HBURST;
    logic            HREADY;
    logic [NMGR-1:0] HGRANT;
    logic [IDXW-1:0] HMASTER;
    logic [IDXW-1:0] HMASTER_D;
    logic            HMASTLOCK;

    // Arbiter side: consumes requests and bus status, drives ownership.
    modport master (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );

    // Manager/interconnect side.
    modport slave (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );
endinterface
`default_nettype wire

// File: rtl/ahb_bus_arbiter_fixedpriority.sv
`default_nettype none
// ============================================================================
// Module   : fixedpriority
// Brief    : One-hot isolation of the lowest-index asserted request bit.
// Revision : 1.0
// ============================================================================
module fixedpriority #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_gnt
);
    // Two's-complement trick keeps only the least-significant set bit.
    assign o_gnt = i_req & (~i_req + WIDTH'(1));
endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bus_arbiter
// Brief    : Registered fixed-priority AHB-Lite arbiter honouring bursts/locks.
//            Define AHBARB_PARK_EN to park an idle bus on manager 0.
// Revision : 1.0
// ============================================================================
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NMGR = 4,
    parameter int IDXW = $clog2(NMGR)
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_bus_arbiter_if.master  bus
);

    logic [NMGR-1:0]    w_next_grant;
    logic [NMGR-1:0]    w_grant_next;
    logic [IDXW-1:0]    w_master;
    logic               w_owner_lock;
    logic               w_accept;
    logic               w_nonseq;
    logic               w_seq;
    logic               w_idle;
    logic               w_arb_pt;
    logic               w_mastlock_next;
    logic [c_BEATW-1:0] w_beat_cnt_next;
    arb_state_e         w_state_next;

    arb_state_e         r_state;
    logic [c_BEATW-1:0] r_beat_cnt;
    logic [NMGR-1:0]    r_grant;
    logic [IDXW-1:0]    r_master_d;
    logic               r_mastlock;

    fixedpriority #(
        .WIDTH (NMGR)
    ) u_fixedpriority (
        .i_req (bus.HBUSREQ),
        .o_gnt (w_next_grant)
    );

    always_comb begin
        w_master = '0;
        for (int i = 0; i < NMGR; i++) begin
            if (r_grant[i]) begin
                w_master = IDXW'(i);
            end
        end
    end

    assign w_owner_lock = bus.HLOCK[w_master];
    assign w_accept     = bus.HREADY & bus.HTRANS[1];
    assign w_nonseq     = w_accept & (bus.HTRANS == c_HTRANS_NONSEQ);
    assign w_seq        = w_accept & (bus.HTRANS == c_HTRANS_SEQ);
    assign w_idle       = bus.HREADY & (bus.HTRANS == c_HTRANS_IDLE);

    always_comb begin
        w_beat_cnt_next = r_beat_cnt;
        if (w_nonseq) begin
            w_beat_cnt_next = burst_beats(bus.HBURST);
        end else if (w_seq && (r_beat_cnt != '0)) begin
            w_beat_cnt_next = r_beat_cnt - 5'd1;
        end else if (w_idle) begin
            w_beat_cnt_next = '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.HREADY) begin
            case (r_state)
                ARB_ST_ARB: begin
                    if (w_nonseq) begin
                        if (w_owner_lock) begin
                            w_state_next = ARB_ST_LOCKED;
                        end else if (w_beat_cnt_next != '0) begin
                            w_state_next = ARB_ST_BURST;
                        end
                    end
                end
                ARB_ST_BURST: begin
                    if (w_nonseq && w_owner_lock) begin
                        w_state_next = ARB_ST_LOCKED;
                    end else if (w_beat_cnt_next == '0) begin
                        w_state_next = ARB_ST_ARB;
                    end
                end
                ARB_ST_LOCKED: begin
                    if (!w_owner_lock && (w_idle || (w_beat_cnt_next == '0))) begin
                        w_state_next = ARB_ST_ARB;
                    end
                end
                default: w_state_next = ARB_ST_ARB;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ARB_ST_ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A locking owner keeps the bus even while idle between its transfers.
    assign w_arb_pt = bus.HREADY & (w_state_next == ARB_ST_ARB) & ~w_owner_lock;

    always_comb begin
        w_grant_next = r_grant;
        if (w_arb_pt) begin
            if (|w_next_grant) begin
                w_grant_next = w_next_grant;
            end
`ifdef AHBARB_PARK_EN
            else begin
                w_grant_next = {{(NMGR-1){1'b0}}, 1'b1};
            end
`endif
        end
    end

    always_comb begin
        w_mastlock_next = r_mastlock;
        if (w_nonseq) begin
            w_mastlock_next = w_owner_lock;
        end else if ((r_state == ARB_ST_LOCKED) && (w_state_next != ARB_ST_LOCKED)) begin
            w_mastlock_next = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_beat_cnt <= '0;
            r_grant    <= {{(NMGR-1){1'b0}}, 1'b1};
            r_master_d <= '0;
            r_mastlock <= 1'b0;
        end else begin
            r_beat_cnt <= w_beat_cnt_next;
            r_grant    <= w_grant_next;
            r_mastlock <= w_mastlock_next;
            if (bus.HREADY) begin
                r_master_d <= w_master;
            end
        end
    end

    assign bus.HGRANT    = r_grant;
    assign bus.HMASTER   = w_master;
    assign bus.HMASTER_D = r_master_d;
    assign bus.HMASTLOCK = r_mastlock;

endmodule
`default_nettype wire
